// File: rtl/fifo_req_issuer.sv
// fifo_req_issuer
//   Pops request entries from the test-request FIFO one at a time and issues
//   them to the memory controller over a valid/ready handshake. Tracks the
//   number of issued-but-unanswered requests against a credit limit and keeps
//   issue/completion statistics.
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   reset_ni       asynchronous active-low reset
//   run_i          1: issuing enabled; 0: finish current request then idle
//   fifo_empty_i   FIFO empty flag
//   fifo_dout_i    FIFO registered read data {is_write, addr, wdata}
//   fifo_rd_en_o   FIFO pop strobe (one cycle per entry)
//   req_valid_o    request valid
//   req_ready_i    controller accepts the request
//   req_we_o       1: write, 0: read
//   req_addr_o     request address
//   req_wdata_o    write data
//   rsp_valid_i    one-cycle pulse per completed request
//   outstanding_o  issued-but-unanswered request count
//   issued_cnt_o   requests accepted since reset (wraps)
//   done_cnt_o     responses received since reset (wraps)
//   err_o          sticky: response seen with nothing outstanding
//   idle_o         idle, FIFO empty and nothing outstanding
module fifo_req_issuer #(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ENTRY_W         = 1 + ADDR_W + DATA_W
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               run_i,
  input  logic               fifo_empty_i,
  input  logic [ENTRY_W-1:0] fifo_dout_i,
  output logic               fifo_rd_en_o,
  output logic               req_valid_o,
  input  logic               req_ready_i,
  output logic               req_we_o,
  output logic [ADDR_W-1:0]  req_addr_o,
  output logic [DATA_W-1:0]  req_wdata_o,
  input  logic               rsp_valid_i,
  output logic [3:0]         outstanding_o,
  output logic [31:0]        issued_cnt_o,
  output logic [31:0]        done_cnt_o,
  output logic               err_o,
  output logic               idle_o
);

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    CREDIT_WAIT,
    ISSUE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  outstanding;
  logic [3:0]  outstanding_nxt;
  logic        handshake;
  logic        rsp_ok;
  logic        credit_ok;
  logic        more_work;

  assign handshake = (state == ISSUE) && req_ready_i;
  // A response with nothing outstanding is an error, not a completion.
  assign rsp_ok    = rsp_valid_i && (outstanding != 4'd0);
  assign more_work = run_i && !fifo_empty_i;

  always_comb begin
    outstanding_nxt = outstanding + 4'(handshake) - 4'(rsp_ok);
  end

  // Credit is judged on the count after this cycle's updates, so a response
  // arriving in LOAD or CREDIT_WAIT frees a slot without an extra cycle.
  assign credit_ok = (outstanding_nxt < MAX_OUT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (more_work) state_nxt = POP;
      POP:         state_nxt = LOAD;
      LOAD:        state_nxt = credit_ok ? ISSUE : CREDIT_WAIT;
      CREDIT_WAIT: if (credit_ok) state_nxt = ISSUE;
      ISSUE:       if (req_ready_i) state_nxt = more_work ? POP : IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // ---- state and control registers ----
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state        <= IDLE;
      outstanding  <= 4'd0;
      issued_cnt_o <= 32'd0;
      done_cnt_o   <= 32'd0;
      err_o        <= 1'b0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
      if (handshake)                    issued_cnt_o <= issued_cnt_o + 32'd1;
      if (rsp_ok)                       done_cnt_o   <= done_cnt_o + 32'd1;
      if (rsp_valid_i && !rsp_ok)       err_o        <= 1'b1;
    end
  end

  // ---- request payload, captured once per entry in LOAD ----
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      req_we_o    <= 1'b0;
      req_addr_o  <= '0;
      req_wdata_o <= '0;
    end else if (state == LOAD) begin
      req_we_o    <= fifo_dout_i[ENTRY_W-1];
      req_addr_o  <= fifo_dout_i[ENTRY_W-2 -: ADDR_W];
      req_wdata_o <= fifo_dout_i[DATA_W-1:0];
    end
  end

  assign fifo_rd_en_o  = (state == POP);
  assign req_valid_o   = (state == ISSUE);
  assign outstanding_o = outstanding;
  // Gated by reset so every output reads 0 while reset is held.
  assign idle_o = reset_ni && (state == IDLE) && fifo_empty_i &&
                  (outstanding == 4'd0);

endmodule

// File: tb/tb_fifo_req_issuer.sv
// tb_fifo_req_issuer
//   Randomized and directed bench for fifo_req_issuer. The bench plays the
//   FIFO (a queue with registered read data) and keeps a transaction-level
//   model: expected request order, outstanding count, statistics and error.
module tb_fifo_req_issuer;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 8;
  localparam int MAX_OUT = 4;
  localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

  logic               clk = 1'b0;
  logic               reset_ni;
  logic               run_i;
  logic               fifo_empty_i;
  logic [ENTRY_W-1:0] fifo_dout_i;
  logic               fifo_rd_en_o;
  logic               req_valid_o;
  logic               req_ready_i;
  logic               req_we_o;
  logic [ADDR_W-1:0]  req_addr_o;
  logic [DATA_W-1:0]  req_wdata_o;
  logic               rsp_valid_i;
  logic [3:0]         outstanding_o;
  logic [31:0]        issued_cnt_o;
  logic [31:0]        done_cnt_o;
  logic               err_o;
  logic               idle_o;

  always #5 clk = ~clk;

  fifo_req_issuer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTSTANDING(MAX_OUT), .ENTRY_W(ENTRY_W)
  ) dut (
    .clk_i(clk), .reset_ni(reset_ni), .run_i(run_i), .fifo_empty_i(fifo_empty_i),
    .fifo_dout_i(fifo_dout_i), .fifo_rd_en_o(fifo_rd_en_o), .req_valid_o(req_valid_o),
    .req_ready_i(req_ready_i), .req_we_o(req_we_o), .req_addr_o(req_addr_o),
    .req_wdata_o(req_wdata_o), .rsp_valid_i(rsp_valid_i), .outstanding_o(outstanding_o),
    .issued_cnt_o(issued_cnt_o), .done_cnt_o(done_cnt_o), .err_o(err_o), .idle_o(idle_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [ENTRY_W-1:0] fifo_q[$];
  logic [ENTRY_W-1:0] exp_q[$];
  int                 out_m;
  logic [31:0]        iss_m;
  logic [31:0]        done_m;
  logic               err_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  task automatic push(input logic [ENTRY_W-1:0] e);
    fifo_q.push_back(e);
    exp_q.push_back(e);
    fifo_empty_i = 1'b0;
  endtask

  task automatic model_clear();
    out_m  = 0;
    iss_m  = 32'd0;
    done_m = 32'd0;
    err_m  = 1'b0;
  endtask

  // One clock: drive inputs at the falling edge, predict the rising edge,
  // then check everything at the next falling edge.
  task automatic step(input logic r, input logic rdy, input logic rs);
    logic               hs, rsp_ok, stall, empty_before, popped;
    logic [ENTRY_W-1:0] pay, nxt;
    run_i       = r;
    req_ready_i = rdy;
    rsp_valid_i = rs;
    nxt         = '0;
    hs = req_valid_o && rdy;
    if (hs) begin
      if (exp_q.size() == 0) begin
        check("exp_q_nonempty", 32'(exp_q.size()), 32'd1);
      end else begin
        check("req_we",   32'(req_we_o),   32'(exp_q[0][ENTRY_W-1]));
        check("req_addr", 32'(req_addr_o), 32'(exp_q[0][ENTRY_W-2 -: ADDR_W]));
        if (exp_q[0][ENTRY_W-1])
          check("req_wdata", 32'(req_wdata_o), 32'(exp_q[0][DATA_W-1:0]));
        void'(exp_q.pop_front());
      end
      iss_m++;
    end
    rsp_ok = rs && (out_m > 0);
    if (rs && out_m == 0) err_m = 1'b1;
    if (rsp_ok) done_m++;
    out_m = out_m + int'(hs) - int'(rsp_ok);
    stall        = req_valid_o && !rdy;
    pay          = {req_we_o, req_addr_o, req_wdata_o};
    empty_before = fifo_empty_i;
    popped       = fifo_rd_en_o;
    if (popped && fifo_q.size() > 0) nxt = fifo_q.pop_front();
    @(negedge clk);
    if (popped) begin
      fifo_dout_i  = nxt;
      fifo_empty_i = (fifo_q.size() == 0);
    end
    check("outstanding", 32'(outstanding_o), 32'(out_m));
    check("issued_cnt",  issued_cnt_o, iss_m);
    check("done_cnt",    done_cnt_o,   done_m);
    check("err",         32'(err_o),   32'(err_m));
    if (stall) begin
      check("valid_held",   32'(req_valid_o), 32'd1);
      check("payload_held", 32'({req_we_o, req_addr_o, req_wdata_o}), 32'(pay));
    end
    if (fifo_rd_en_o) check("pop_when_empty", 32'(empty_before), 32'd0);
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (exp_q.size() == 0 && out_m == 0 && idle_o) begin
        done = 1'b1;
        break;
      end
      step(1'b1, 1'b1, out_m > 0);
    end
    check("drain_done", 32'(done), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base_iss, base_done;
    logic        reached;
    int          pops;

    reset_ni = 1'b0; run_i = 1'b0; req_ready_i = 1'b0; rsp_valid_i = 1'b0;
    fifo_empty_i = 1'b1; fifo_dout_i = '0;
    model_clear();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rd_en", 32'(fifo_rd_en_o), 32'd0);
    check("rst_valid", 32'(req_valid_o),  32'd0);
    check("rst_addr",  32'(req_addr_o),   32'd0);
    check("rst_out",   32'(outstanding_o), 32'd0);
    check("rst_iss",   issued_cnt_o, 32'd0);
    check("rst_idle",  32'(idle_o), 32'd0);
    reset_ni = 1'b1;
    @(negedge clk);
    check("idle_after_reset", 32'(idle_o), 32'd1);

    // Single write request, pop-to-valid latency
    push({1'b1, 16'h0040, 8'hA5});
    step(1'b1, 1'b1, 1'b0);
    check("t1_pop",      32'(fifo_rd_en_o), 32'd1);
    step(1'b1, 1'b1, 1'b0);
    check("t1_pop_once", 32'(fifo_rd_en_o), 32'd0);
    check("t1_no_valid", 32'(req_valid_o),  32'd0);
    step(1'b1, 1'b1, 1'b0);
    check("t1_valid", 32'(req_valid_o), 32'd1);
    check("t1_we",    32'(req_we_o),    32'd1);
    check("t1_addr",  32'(req_addr_o),  32'h0040);
    check("t1_wdata", 32'(req_wdata_o), 32'hA5);
    step(1'b1, 1'b1, 1'b0);
    check("t1_issued", issued_cnt_o,        32'd1);
    check("t1_out",    32'(outstanding_o),  32'd1);
    step(1'b1, 1'b0, 1'b1);

    // Ready held low for 5 cycles
    push({1'b0, 16'h1234, 8'h5C});
    reached = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (req_valid_o) begin reached = 1'b1; break; end
      step(1'b1, 1'b0, 1'b0);
    end
    check("t2_valid_reached", 32'(reached), 32'd1);
    base_iss = iss_m;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0);
      check("t2_stall_valid", 32'(req_valid_o), 32'd1);
      check("t2_stall_addr",  32'(req_addr_o),  32'h1234);
      check("t2_stall_iss",   issued_cnt_o,     base_iss);
    end
    step(1'b1, 1'b1, 1'b0);
    check("t2_iss_after_ready", issued_cnt_o, base_iss + 32'd1);
    drain();

    // Credit limit with 6 entries and no responses
    base_iss = iss_m;
    for (int k = 0; k < 6; k++) push({k[0], 16'h0100 + 16'(k), 8'(k * 17)});
    reached = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (iss_m == base_iss + 32'd4) begin reached = 1'b1; break; end
      step(1'b1, 1'b1, 1'b0);
    end
    check("t3_four_issued", 32'(reached), 32'd1);
    repeat (4) step(1'b1, 1'b1, 1'b0);
    check("t3_blocked_valid", 32'(req_valid_o),   32'd0);
    check("t3_blocked_out",   32'(outstanding_o), 32'd4);
    check("t3_blocked_iss",   issued_cnt_o,       base_iss + 32'd4);
    step(1'b1, 1'b1, 1'b1);
    check("t3_resume_valid", 32'(req_valid_o),   32'd1);
    check("t3_resume_out",   32'(outstanding_o), 32'd3);
    step(1'b1, 1'b1, 1'b0);
    check("t3_fifth_out", 32'(outstanding_o), 32'd4);
    check("t3_fifth_iss", issued_cnt_o,       base_iss + 32'd5);
    drain();

    // Handshake and response in the same cycle with 2 outstanding
    for (int k = 0; k < 3; k++) push({1'b1, 16'h2000 + 16'(k), 8'h30 + 8'(k)});
    reached = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (req_valid_o && out_m == 2) begin reached = 1'b1; break; end
      step(1'b1, 1'b1, 1'b0);
    end
    check("t4_setup", 32'(reached), 32'd1);
    base_iss  = iss_m;
    base_done = done_m;
    step(1'b1, 1'b1, 1'b1);
    check("t4_out",  32'(outstanding_o), 32'd2);
    check("t4_iss",  issued_cnt_o, base_iss + 32'd1);
    check("t4_done", done_cnt_o,   base_done + 32'd1);
    drain();

    // run_i dropped during LOAD with 3 entries queued
    base_iss = iss_m;
    for (int k = 0; k < 3; k++) push({1'b0, 16'h3000 + 16'(k), 8'h00});
    reached = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (fifo_rd_en_o) begin reached = 1'b1; break; end
      step(1'b1, 1'b1, 1'b0);
    end
    check("t5_first_pop", 32'(reached), 32'd1);
    step(1'b1, 1'b1, 1'b0);
    pops = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (fifo_rd_en_o) pops++;
      check("t5_not_idle", 32'(idle_o), 32'd0);
    end
    check("t5_no_pop", 32'(pops), 32'd0);
    check("t5_iss",    issued_cnt_o, base_iss + 32'd1);
    drain();
    check("t5_all_iss", issued_cnt_o, base_iss + 32'd3);
    check("t5_idle",    32'(idle_o), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (($urandom % 4 == 0) && fifo_q.size() < 8)
        push(ENTRY_W'($urandom));
      step(($urandom % 5) != 0, 1'($urandom % 2), (out_m > 0) && ($urandom % 3 == 0));
    end
    drain();

    // Response with nothing outstanding
    check("t7_err_clear", 32'(err_o), 32'd0);
    base_done = done_m;
    step(1'b1, 1'b0, 1'b1);
    check("t7_err_set",  32'(err_o),     32'd1);
    check("t7_done",     done_cnt_o,     base_done);
    check("t7_out_zero", 32'(outstanding_o), 32'd0);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    check("t7_err_sticky", 32'(err_o), 32'd1);

    // Asynchronous reset while a request is presented
    push({1'b1, 16'hBEEF, 8'h77});
    reached = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (req_valid_o) begin reached = 1'b1; break; end
      step(1'b1, 1'b0, 1'b0);
    end
    check("t8_in_issue", 32'(reached), 32'd1);
    #2 reset_ni = 1'b0;
    #1;
    check("t8_valid", 32'(req_valid_o),   32'd0);
    check("t8_rd_en", 32'(fifo_rd_en_o),  32'd0);
    check("t8_we",    32'(req_we_o),      32'd0);
    check("t8_addr",  32'(req_addr_o),    32'd0);
    check("t8_wdata", 32'(req_wdata_o),   32'd0);
    check("t8_out",   32'(outstanding_o), 32'd0);
    check("t8_iss",   issued_cnt_o,       32'd0);
    check("t8_done",  done_cnt_o,         32'd0);
    check("t8_err",   32'(err_o),         32'd0);
    check("t8_idle",  32'(idle_o),        32'd0);
    void'(exp_q.pop_front());
    model_clear();
    @(negedge clk);
    reset_ni = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("t8_idle_after", 32'(idle_o), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_req_issuer.md
Name: fifo_req_issuer

Overview:
- Downstream consumer of the test-request FIFO in the Lease Cache controller bench.
- Pops one request entry at a time and drives it to the memory controller over a valid/ready handshake.
- Tracks outstanding (unanswered) requests against a credit limit and keeps issue/completion statistics.

Parameters:
- ADDR_W, 16, request address width
- DATA_W, 8, write-data width
- MAX_OUTSTANDING, 4, maximum issued-but-unanswered requests (1..15)
- ENTRY_W, 1+ADDR_W+DATA_W, FIFO entry width; entry = {is_write, addr, wdata} with is_write in the MSB

Ports:
- clk_i  in  1  single clock; all state changes on rising edge
- reset_ni  in  1  asynchronous, active-low reset
- run_i  in  1  1: issuing enabled; 0: finish current request, then hold in IDLE
- fifo_empty_i  in  1  FIFO empty flag
- fifo_dout_i  in  ENTRY_W  FIFO registered read data; valid the cycle after a pop
- fifo_rd_en_o  out  1  FIFO pop strobe
- req_valid_o  out  1  request valid
- req_ready_i  in  1  controller accepts the request
- req_we_o  out  1  1: write, 0: read
- req_addr_o  out  ADDR_W  request address
- req_wdata_o  out  DATA_W  write data (don't-care for reads)
- rsp_valid_i  in  1  one-cycle pulse per completed request
- outstanding_o  out  4  current outstanding count
- issued_cnt_o  out  32  requests accepted since reset
- done_cnt_o  out  32  responses received since reset
- err_o  out  1  sticky: response received while outstanding == 0
- idle_o  out  1  state IDLE, fifo_empty_i=1 and outstanding == 0

Behaviour:
- Reset (reset_ni=0, async): state IDLE; all outputs 0; request registers 0.
- States: IDLE, POP, LOAD, CREDIT_WAIT, ISSUE. Encoding is free.
- fifo_rd_en_o = (state == POP). It is exactly one cycle per entry and is never asserted when fifo_empty_i was 1 on the entry edge.
- IDLE -> POP when run_i && !fifo_empty_i; otherwise stay in IDLE.
- POP -> LOAD unconditionally. The FIFO updates fifo_dout_i at the end of POP.
- LOAD:
  - Capture fifo_dout_i into req_we_o/req_addr_o/req_wdata_o.
  - -> ISSUE if the outstanding count after this cycle's updates is < MAX_OUTSTANDING; otherwise -> CREDIT_WAIT.
- CREDIT_WAIT -> ISSUE on the first cycle a response brings outstanding below MAX_OUTSTANDING.
- ISSUE:
  - req_valid_o=1. Payload is stable until the handshake completes.
  - valid is never withdrawn before ready.
  - On req_ready_i: outstanding+1 and issued_cnt+1. Next state is POP if run_i && !fifo_empty_i, else IDLE.
- Latency and throughput:
  - Pop to req_valid_o = 2 cycles, with no credit stall.
  - Best-case throughput is 1 request per 3 cycles (POP, LOAD, ISSUE with ready high).
- Outstanding counter:
  - Increment on handshake, decrement on rsp_valid_i.
  - Simultaneous handshake and response: count unchanged; issued_cnt and done_cnt each +1.
  - rsp_valid_i with outstanding == 0: count stays 0, err_o set until reset, done_cnt not incremented.
- Statistics counters wrap modulo 2^32 with no saturation.
- run_i deasserted mid-request: the current POP/LOAD/ISSUE sequence completes normally, and no further pop occurs.
- Responses are counted in every state, including IDLE.
- Async reset mid-ISSUE: req_valid_o drops immediately and the request is lost (the bench must not count it).
- req_valid_o, req_* and fifo_rd_en_o are decoded from registered state/registers only. There are no combinational paths from req_ready_i or rsp_valid_i to outputs.

Test Plan:
- Reset then run_i=1, preload FIFO with {1,16'h0040,8'hA5}, req_ready_i=1 -> fifo_rd_en_o pulses 1 cycle; 2 cycles later req_valid_o=1, req_we_o=1, req_addr_o=16'h0040, req_wdata_o=8'hA5; issued_cnt_o=1, outstanding_o=1.
- req_ready_i held 0 for 5 cycles in ISSUE -> req_valid_o stays 1 and payload unchanged for all 5 cycles; counters advance only on the ready cycle.
- MAX_OUTSTANDING=4, 6 entries, no responses -> 4 accepted, FSM in CREDIT_WAIT; one rsp_valid_i pulse -> 5th request issued next cycle, outstanding_o returns to 4.
- Handshake and rsp_valid_i in the same cycle with outstanding_o=2 -> outstanding_o stays 2; issued_cnt_o and done_cnt_o both +1.
- rsp_valid_i with outstanding_o=0 -> err_o=1 and remains 1; done_cnt_o unchanged; cleared only by reset_ni=0.
- run_i dropped during LOAD with 3 entries queued -> that request completes, no further pop; idle_o=0 until run_i returns and the FIFO drains and all responses arrive. Assert reset_ni=0 mid-ISSUE -> all outputs 0 in the same cycle.
